// File: rtl/tt_sweep_ctrl_if.sv
// Bundles the sweep controller's command, gate-stimulus and result signals.
// The master side commands sweeps and models the gate; the slave side is the controller.
interface tt_sweep_ctrl_if #(
  parameter int unsigned SETTLE_W = 4
);
  logic                start;
  logic                abort;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [7:0]          expected;
  logic                y_in;
  logic                a;
  logic                b;
  logic                c;
  logic                busy;
  logic                sample_valid;
  logic [2:0]          sample_idx;
  logic [7:0]          truth_table;
  logic                done;
  logic                pass;

  modport master (
    output start,
    output abort,
    output settle_cycles,
    output expected,
    output y_in,
    input  a,
    input  b,
    input  c,
    input  busy,
    input  sample_valid,
    input  sample_idx,
    input  truth_table,
    input  done,
    input  pass
  );

  modport slave (
    input  start,
    input  abort,
    input  settle_cycles,
    input  expected,
    input  y_in,
    output a,
    output b,
    output c,
    output busy,
    output sample_valid,
    output sample_idx,
    output truth_table,
    output done,
    output pass
  );
endinterface

// File: rtl/tt_sweep_ctrl.sv
// Exhaustive truth-table sweep of a 3-input gate: drives all 8 vectors in ascending order,
// holds each for a programmable settle time, captures y_in and compares against a golden table.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_W = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  tt_sweep_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [7:0]          exp_q, exp_d;
  logic [7:0]          tt_q, tt_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          abc_q, abc_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    idx_d    = idx_q;
    abc_d    = abc_q;
    pass_d   = pass_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          // A zero settle time would skip the hold entirely; treat it as one cycle.
          settle_d = (bus.settle_cycles == '0) ? SETTLE_W'(1) : bus.settle_cycles;
          exp_d    = bus.expected;
          tt_d     = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          abc_d    = '0;
          cnt_d    = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (bus.abort) begin
          abc_d   = '0;
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (cnt_q == settle_q - 1'b1) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        if (bus.abort) begin
          abc_d   = '0;
          pass_d  = 1'b0;
          state_d = StIdle;
        end else begin
          tt_d[idx_q] = bus.y_in;
          if (idx_q == 3'd7) begin
            abc_d   = '0;
            state_d = StDone;
          end else begin
            // Next vector is presented on the same edge that captures this one.
            idx_d   = idx_q + 3'd1;
            abc_d   = idx_q + 3'd1;
            cnt_d   = '0;
            state_d = StSettle;
          end
        end
      end
      StDone: begin
        // done and pass register together so both are valid in the same cycle.
        pass_d  = (tt_q == exp_q);
        done_d  = 1'b1;
        abc_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      settle_q <= '0;
      cnt_q    <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      idx_q    <= '0;
      abc_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      idx_q    <= idx_d;
      abc_q    <= abc_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
    end
  end

  assign bus.a            = abc_q[2];
  assign bus.b            = abc_q[1];
  assign bus.c            = abc_q[0];
  assign bus.busy         = (state_q == StSettle) || (state_q == StSample);
  // An abort in the capture cycle cancels the capture, so the pulse is withheld too.
  assign bus.sample_valid = (state_q == StSample) && !bus.abort;
  assign bus.sample_idx   = idx_q;
  assign bus.truth_table  = tt_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomized bench for tt_sweep_ctrl: a table-driven gate model and a cycle-position
// reference (vector = edge / (S+1), capture when edge % (S+1) == S) check every cycle.
module tb_tt_sweep_ctrl;
  localparam int unsigned SettleW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lut = '0;
  int         n_chk = 0;
  int         n_fail = 0;

  tt_sweep_ctrl_if #(.SETTLE_W(SettleW)) bus ();

  // Gate under test: arbitrary 3-input function given as a lookup table, index {a,b,c}.
  assign bus.y_in = lut[{bus.a, bus.b, bus.c}];

  tt_sweep_ctrl #(.SETTLE_W(SettleW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // a is the MSB of the vector index, so y=a&b|c tabulates to 8'hEA and a^b^c to 8'h96.
  function automatic logic [7:0] tabulate(input int kind);
    logic [7:0] t;
    logic [2:0] i3;
    t = '0;
    for (int i = 0; i < 8; i++) begin
      i3   = 3'(i);
      t[i] = (kind == 0) ? ((i3[2] & i3[1]) | i3[0]) : (i3[2] ^ i3[1] ^ i3[0]);
    end
    return t;
  endfunction

  task automatic chk_quiet(input string tag, input int cycles);
    int n_bad;
    n_bad = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.sample_valid) n_bad++;
    end
    chk(tag, 32'(n_bad), 0);
  endtask

  // mode 0: full sweep; 1: abort raised after edge stop_at; 2: reset pulsed after edge stop_at.
  task automatic sweep(input int s_in, input logic [7:0] expv, input int mode, input int stop_at);
    int         s_eff, per, last, v, extra;
    bit         smp;
    logic [7:0] tt_exp;
    s_eff  = (s_in == 0) ? 1 : s_in;
    per    = s_eff + 1;
    last   = 8 * per + 1;
    tt_exp = '0;
    extra  = int'($urandom_range(0, last - 1));
    @(negedge clk);
    bus.settle_cycles = SettleW'(s_in);
    bus.expected      = expv;
    bus.abort         = 1'b0;
    bus.start         = 1'b1;
    for (int e = 0; e <= last + 1; e++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (e == 0) begin
        bus.settle_cycles = SettleW'($urandom);
        bus.expected      = 8'($urandom);
      end
      if (e == last) begin
        chk("done_pulse", 32'(bus.done), 1);
        chk("done_busy", 32'(bus.busy), 0);
        chk("done_pass", 32'(bus.pass), 32'(lut == expv));
        chk("done_tt", 32'(bus.truth_table), 32'(lut));
      end else if (e == last + 1) begin
        chk("after_done", 32'(bus.done), 0);
        chk("pass_hold", 32'(bus.pass), 32'(lut == expv));
        chk("tt_hold", 32'(bus.truth_table), 32'(lut));
      end else if (e == last - 1) begin
        chk("fin_busy", 32'(bus.busy), 0);
        chk("fin_abc", 32'({bus.a, bus.b, bus.c}), 0);
        chk("fin_sv", 32'(bus.sample_valid), 0);
        chk("fin_done", 32'(bus.done), 0);
        chk("fin_tt", 32'(bus.truth_table), 32'(lut));
      end else begin
        v   = e / per;
        smp = (e % per) == s_eff;
        chk("busy", 32'(bus.busy), 1);
        chk("abc", 32'({bus.a, bus.b, bus.c}), 32'(v));
        chk("sample_valid", 32'(bus.sample_valid), 32'(smp));
        chk("done_early", 32'(bus.done), 0);
        chk("pass_early", 32'(bus.pass), 0);
        chk("tt_partial", 32'(bus.truth_table), 32'(tt_exp));
        if (smp) chk("sample_idx", 32'(bus.sample_idx), 32'(v));
        if (mode == 1 && e == stop_at) begin
          bus.abort = 1'b1;
          #1;
          chk("abort_sv", 32'(bus.sample_valid), 0);
          @(posedge clk); #1;
          bus.abort = 1'b0;
          chk("abort_busy", 32'(bus.busy), 0);
          chk("abort_abc", 32'({bus.a, bus.b, bus.c}), 0);
          chk("abort_tt", 32'(bus.truth_table), 32'(tt_exp));
          chk("abort_pass", 32'(bus.pass), 0);
          chk_quiet("abort_quiet", last);
          return;
        end
        if (mode == 2 && e == stop_at) begin
          rst_n = 1'b0;
          #1;
          chk("rst_async", 32'({bus.busy, bus.a, bus.b, bus.c, bus.sample_valid, bus.sample_idx,
                                bus.truth_table, bus.pass, bus.done}), 0);
          @(negedge clk);
          rst_n = 1'b1;
          chk_quiet("rst_quiet", 6);
          return;
        end
        if (smp) tt_exp[v] = lut[v];
      end
      if (e == extra) bus.start = 1'b1;
    end
  endtask

  initial begin
    int s;
    int n_sv;
    bus.start         = 1'b0;
    bus.abort         = 1'b0;
    bus.settle_cycles = '0;
    bus.expected      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({bus.busy, bus.a, bus.b, bus.c, bus.sample_valid, bus.sample_idx,
                              bus.truth_table, bus.pass, bus.done}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    lut = tabulate(0);
    sweep(1, lut, 0, 0);
    // Pass and table persist in IDLE regardless of input changes.
    bus.expected = ~lut;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_pass_hold", 32'(bus.pass), 1);
    chk("idle_tt_hold", 32'(bus.truth_table), 32'(lut));

    sweep(0, lut, 0, 0);
    sweep(4, lut, 0, 0);

    lut = tabulate(1);
    sweep(2, 8'hFF, 0, 0);

    // start with abort in IDLE must not launch a sweep.
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    n_sv = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.sample_valid || bus.busy) n_sv++;
    end
    chk("start_abort_quiet", 32'(n_sv), 0);

    lut = 8'($urandom);
    s = int'($urandom_range(1, 6));
    sweep(s, lut, 1, 3 * (s + 1) + int'($urandom_range(0, s - 1)));
    sweep(s, lut, 1, 2 * (s + 1) + s);
    sweep(s, lut, 2, 5 * (s + 1) + int'($urandom_range(0, s)));
    sweep(s, lut, 0, 0);

    repeat (6) begin
      lut = 8'($urandom);
      s   = int'($urandom_range(0, 15));
      sweep(s, ($urandom_range(0, 1) == 0) ? lut : 8'($urandom), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
